alu_issue_unit: RTL and testbench
=================================

Name: alu_issue_unit

Overview:
Execute-stage front end that drives the combinational ALU. It accepts 16-bit Thumb data-processing instructions over a valid/ready handshake and decodes them to an ALU opcode. It reads operands from the register file, captures the ALU result and flags, and issues a register writeback. It owns the architectural APSR NZCV register, updating it with ARMv7-M flag-preservation rules.

Parameters:
RF_AW, 3, register-file address width (R0-R7, low registers only)
DW, 32, datapath width; fixed to the ALU width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  unit can accept; high only in IDLE
instr  in  16  Thumb-16 instruction
flush  in  1  abort the in-flight instruction
rf_raddr_a  out  3  first operand register address (Rn/Rdn)
rf_raddr_b  out  3  second operand register address (Rm)
rf_rdata_a  in  32  combinational read data for rf_raddr_a
rf_rdata_b  in  32  combinational read data for rf_raddr_b
alu_opcode  out  alu_op_t  to ALU
alu_a  out  32  ALU data_in1
alu_b  out  32  ALU data_in2
alu_result  in  32  ALU data_out
alu_flags  in  alu_flags_t  ALU flags_out {n,z,c,v}
wb_valid  out  1  one-cycle writeback strobe
wb_addr  out  3  destination register
wb_data  out  32  writeback value
illegal  out  1  one-cycle pulse for an unsupported encoding
apsr_nzcv  out  4  architectural flags {N,Z,C,V}

Behaviour:
- Reset: state=IDLE, apsr_nzcv=4'b0000, wb_valid=0, wb_addr=0, wb_data=0, illegal=0, captured instr=0. instr_ready=1 in the first cycle after reset.
- FSM states:
  - IDLE: instr_ready=1. On instr_valid&&!flush, register instr and go to EXEC.
  - EXEC: drive rf addresses and the ALU from the registered instr. On the clock edge, register the result and flags into wb regs, update APSR, and go to WB.
  - WB: wb_valid=1 (or illegal=1). Return to IDLE.
- Throughput is 1 instruction per 3 cycles. If accepted at edge k: wb_valid is high in cycle k+2, and apsr_nzcv already holds the new value in that cycle.
- Decode:
  - 0001100 Rm Rn Rd: ADD. Uses ALU_ADD, writes Rd.
  - 0001101 Rm Rn Rd: SUB. Uses ALU_SUB, writes Rd.
  - 010000 op Rm Rdn, by op:
    - 0000 AND → ALU_AND, write Rdn
    - 0001 EOR → ALU_EOR, write Rdn
    - 0010 LSL → ALU_LSL, write Rdn
    - 0011 LSR → ALU_LSR, write Rdn
    - 0100 ASR → ALU_ASR, write Rdn
    - 1000 TST → ALU_AND, no writeback
    - 1010 CMP → ALU_SUB, no writeback
    - 1011 CMN → ALU_ADD, no writeback
    - 1100 ORR → ALU_ORR, write Rdn
  - Every other encoding is illegal.
- Operands: alu_a = rf_rdata_a, alu_b = rf_rdata_b.
  - Shift amount is alu_b[4:0] only; amounts of 32 or more alias modulo 32.
- Outside EXEC: alu_opcode=ALU_ADD, alu_a=0, alu_b=0, rf addresses=0.
- Flag update, applied at the end of EXEC:
  - ADD/SUB/CMP/CMN: N,Z,C,V all take the ALU values.
  - AND/EOR/ORR/TST: N,Z update; C,V are preserved.
  - LSL/LSR/ASR: N,Z update; V is preserved. C takes the ALU value only if alu_b[4:0]!=0, otherwise it is preserved.
- Illegal: no writeback and APSR unchanged. illegal=1 for exactly the WB cycle.
- wb_valid is a single-cycle pulse with no backpressure. wb_addr and wb_data hold their last values when wb_valid=0.
- flush:
  - In EXEC: no APSR update, no wb_valid, no illegal; next state is IDLE.
  - In WB: the already-registered writeback completes, because APSR was updated at the previous edge.
  - In IDLE together with instr_valid: no accept.
- rst mid-operation: the in-flight instruction is dropped and all reset values apply on the next edge.
- instr_valid in EXEC/WB is ignored (instr_ready=0). The source must hold instr stable until the handshake.

Test Plan:
- ADD 0x1842 (R2=R0+R1), R0=0x7FFFFFFF, R1=0x00000001 → wb_valid in cycle k+2, wb_addr=2, wb_data=0x80000000, apsr_nzcv=4'b1001.
- CMP 0x4288, R0=5, R1=5 → no wb_valid, apsr_nzcv=4'b0110, instr_ready back high in cycle k+3.
- LSR 0x40E3, R3=0x00000003, R4=1, prior APSR=4'b0001 → wb_addr=3, wb_data=0x00000001, apsr_nzcv=4'b0011. Repeat with R4=0 → wb_data=3, C preserved.
- AND 0x4008, R0=0xF0, R1=0x0F, prior APSR=4'b0011 → wb_data=0, apsr_nzcv=4'b0111 (C and V preserved).
- MUL 0x4340 → illegal=1 for one cycle, wb_valid=0, apsr_nzcv unchanged.
- Flush and reset:
  - ADD 0x1842 with flush=1 in EXEC → no wb_valid, APSR unchanged, next instruction accepted in the following cycle.
  - rst asserted in WB → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: Thumb-16 data-processing issue stage driving an external ALU, owning APSR NZCV.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr_valid/ready, instr instruction handshake (ready only in IDLE)
//   flush                    drops the instruction held in EXEC, blocks acceptance in IDLE
//   rf_raddr_a/b, rf_rdata_a/b  register-file read port (combinational data)
//   alu_opcode, alu_a, alu_b ALU drive; alu_result, alu_flags {n,z,c,v} ALU response
//   wb_valid, wb_addr, wb_data  one-cycle register writeback
//   illegal                  one-cycle pulse for an unsupported encoding
//   apsr_nzcv                architectural flags {N,Z,C,V}
module alu_issue_unit #(
    parameter int RF_AW = 3,
    parameter int DW = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    input  logic             flush,
    output logic [RF_AW-1:0] rf_raddr_a,
    output logic [RF_AW-1:0] rf_raddr_b,
    input  logic [DW-1:0]    rf_rdata_a,
    input  logic [DW-1:0]    rf_rdata_b,
    output logic [3:0]       alu_opcode,
    output logic [DW-1:0]    alu_a,
    output logic [DW-1:0]    alu_b,
    input  logic [DW-1:0]    alu_result,
    input  logic [3:0]       alu_flags,
    output logic             wb_valid,
    output logic [RF_AW-1:0] wb_addr,
    output logic [DW-1:0]    wb_data,
    output logic             illegal,
    output logic [3:0]       apsr_nzcv
);
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_ORR = 4'd3,
                           ALU_EOR = 4'd4, ALU_LSL = 4'd5, ALU_LSR = 4'd6, ALU_ASR = 4'd7;
    localparam logic [1:0] F_ARITH = 2'd0, F_LOGIC = 2'd1, F_SHIFT = 2'd2;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t            state_q, state_d;
    logic [15:0]       instr_q;
    logic              wb_valid_q, illegal_q;
    logic [RF_AW-1:0]  wb_addr_q;
    logic [DW-1:0]     wb_data_q;
    logic [3:0]        apsr_q, apsr_d;
    logic              legal, we, in_exec, commit;
    logic [3:0]        opc;
    logic [1:0]        fcls;
    logic [RF_AW-1:0]  ra, rb, dst;

    always_comb begin
        legal = 1'b0;
        we    = 1'b0;
        opc   = ALU_ADD;
        fcls  = F_ARITH;
        ra    = instr_q[2:0];
        rb    = instr_q[5:3];
        dst   = instr_q[2:0];
        if (instr_q[15:10] == 6'b000110) begin
            legal = 1'b1;
            we    = 1'b1;
            opc   = instr_q[9] ? ALU_SUB : ALU_ADD;
            ra    = instr_q[5:3];
            rb    = instr_q[8:6];
        end else if (instr_q[15:10] == 6'b010000) begin
            legal = 1'b1;
            we    = 1'b1;
            case (instr_q[9:6])
                4'b0000: begin opc = ALU_AND; fcls = F_LOGIC; end
                4'b0001: begin opc = ALU_EOR; fcls = F_LOGIC; end
                4'b0010: begin opc = ALU_LSL; fcls = F_SHIFT; end
                4'b0011: begin opc = ALU_LSR; fcls = F_SHIFT; end
                4'b0100: begin opc = ALU_ASR; fcls = F_SHIFT; end
                4'b1000: begin opc = ALU_AND; fcls = F_LOGIC; we = 1'b0; end
                4'b1010: begin opc = ALU_SUB; we = 1'b0; end
                4'b1011: begin opc = ALU_ADD; we = 1'b0; end
                4'b1100: begin opc = ALU_ORR; fcls = F_LOGIC; end
                default: begin legal = 1'b0; we = 1'b0; end
            endcase
        end
    end

    assign in_exec     = state_q == EXEC;
    assign commit      = in_exec && !flush && legal;
    assign instr_ready = state_q == IDLE;
    assign rf_raddr_a  = in_exec ? ra : '0;
    assign rf_raddr_b  = in_exec ? rb : '0;
    assign alu_opcode  = in_exec ? opc : ALU_ADD;
    assign alu_a       = in_exec ? rf_rdata_a : '0;
    assign alu_b       = in_exec ? rf_rdata_b : '0;
    assign wb_valid    = wb_valid_q;
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;
    assign illegal     = illegal_q;
    assign apsr_nzcv   = apsr_q;

    // Shifts by zero (after the mod-32 alias) shift nothing out, so C keeps its old value.
    always_comb begin
        apsr_d = fcls == F_ARITH ? alu_flags :
                 fcls == F_LOGIC ? {alu_flags[3:2], apsr_q[1:0]} :
                                   {alu_flags[3:2], (|alu_b[4:0]) ? alu_flags[1] : apsr_q[1], apsr_q[0]};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (instr_valid && !flush) ? EXEC : IDLE;
            EXEC:    state_d = flush ? IDLE : WB;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            wb_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            apsr_q     <= '0;
        end else begin
            state_q    <= state_d;
            if (state_q == IDLE && instr_valid && !flush) instr_q <= instr;
            wb_valid_q <= commit && we;
            illegal_q  <= in_exec && !flush && !legal;
            if (commit && we) begin
                wb_addr_q <= dst;
                wb_data_q <= alu_result;
            end
            if (commit) apsr_q <= apsr_d;
        end
    end
endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: table-driven and directed checks of alu_issue_unit against a bench ALU and register file.
module tb_alu_issue_unit;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_ORR = 4'd3,
                           ALU_EOR = 4'd4, ALU_LSL = 4'd5, ALU_LSR = 4'd6, ALU_ASR = 4'd7;

    logic        clk = 1'b0, rst = 1'b1, instr_valid = 1'b0, flush = 1'b0;
    logic        instr_ready, wb_valid, illegal;
    logic [15:0] instr = '0;
    logic [2:0]  rf_raddr_a, rf_raddr_b, wb_addr;
    logic [31:0] rf_rdata_a, rf_rdata_b, alu_a, alu_b, alu_result, wb_data;
    logic [3:0]  alu_opcode, alu_flags, apsr_nzcv;
    logic [31:0] rf [8];
    int          n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    alu_issue_unit dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .flush(flush), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .alu_opcode(alu_opcode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_flags(alu_flags),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .illegal(illegal),
        .apsr_nzcv(apsr_nzcv)
    );

    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];

    logic [32:0] t;
    logic [4:0]  sh;
    logic        c, v;
    always_comb begin
        sh = alu_b[4:0];
        t = '0;
        v = 1'b0;
        case (alu_opcode)
            ALU_ADD: begin
                t = {1'b0, alu_a} + {1'b0, alu_b};
                v = (alu_a[31] == alu_b[31]) && (t[31] != alu_a[31]);
            end
            ALU_SUB: begin
                t = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                v = (alu_a[31] != alu_b[31]) && (t[31] != alu_a[31]);
            end
            ALU_AND: t = {1'b0, alu_a & alu_b};
            ALU_ORR: t = {1'b0, alu_a | alu_b};
            ALU_EOR: t = {1'b0, alu_a ^ alu_b};
            ALU_LSL: t = {1'b0, alu_a} << sh;
            ALU_LSR: t = {alu_a, 1'b0} >> sh;
            ALU_ASR: t = $signed({alu_a, 1'b0}) >>> sh;
            default: t = '0;
        endcase
        if (alu_opcode == ALU_LSR || alu_opcode == ALU_ASR) begin
            alu_result = t[32:1];
            c = t[0];
        end else begin
            alu_result = t[31:0];
            c = t[32];
        end
        alu_flags = {alu_result[31], alu_result == 32'd0, c, v};
    end

    typedef struct {
        logic [15:0] instr;
        logic [2:0]  aa;
        logic [31:0] va;
        logic [2:0]  ab;
        logic [31:0] vb;
        logic        wb;
        logic        ill;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic [3:0]  apsr;
    } vec_t;

    vec_t vt [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t x, input int i);
        @(negedge clk);
        rf[x.aa] = x.va;
        rf[x.ab] = x.vb;
        chk($sformatf("v%0d ready_idle", i), {31'b0, instr_ready}, 32'd1);
        instr = x.instr;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d ready_exec", i), {31'b0, instr_ready}, 32'd0);
        if (!x.ill) begin
            chk($sformatf("v%0d raddr_a", i), {29'b0, rf_raddr_a}, {29'b0, x.aa});
            chk($sformatf("v%0d raddr_b", i), {29'b0, rf_raddr_b}, {29'b0, x.ab});
        end
        @(negedge clk);
        chk($sformatf("v%0d wb_valid", i), {31'b0, wb_valid}, {31'b0, x.wb});
        chk($sformatf("v%0d illegal", i), {31'b0, illegal}, {31'b0, x.ill});
        chk($sformatf("v%0d apsr", i), {28'b0, apsr_nzcv}, {28'b0, x.apsr});
        if (x.wb) begin
            chk($sformatf("v%0d wb_addr", i), {29'b0, wb_addr}, {29'b0, x.wa});
            chk($sformatf("v%0d wb_data", i), wb_data, x.wd);
        end
        @(negedge clk);
        chk($sformatf("v%0d pulse_end", i), {30'b0, wb_valid, illegal}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = '0;
        vt[0]  = '{16'h1842, 3'd0, 32'h7FFFFFFF, 3'd1, 32'h1, 1'b1, 1'b0, 3'd2, 32'h80000000, 4'b1001};
        vt[1]  = '{16'h4288, 3'd0, 32'h5, 3'd1, 32'h5, 1'b0, 1'b0, 3'd0, 32'h0, 4'b0110};
        vt[2]  = '{16'h1842, 3'd0, 32'h7FFFFFFF, 3'd1, 32'h1, 1'b1, 1'b0, 3'd2, 32'h80000000, 4'b1001};
        vt[3]  = '{16'h4008, 3'd0, 32'h1, 3'd1, 32'h1, 1'b1, 1'b0, 3'd0, 32'h1, 4'b0001};
        vt[4]  = '{16'h40E3, 3'd3, 32'h3, 3'd4, 32'h1, 1'b1, 1'b0, 3'd3, 32'h1, 4'b0011};
        vt[5]  = '{16'h40E3, 3'd3, 32'h3, 3'd4, 32'h0, 1'b1, 1'b0, 3'd3, 32'h3, 4'b0011};
        vt[6]  = '{16'h40E3, 3'd3, 32'h3, 3'd4, 32'd33, 1'b1, 1'b0, 3'd3, 32'h1, 4'b0011};
        vt[7]  = '{16'h40E3, 3'd3, 32'h3, 3'd4, 32'd32, 1'b1, 1'b0, 3'd3, 32'h3, 4'b0011};
        vt[8]  = '{16'h4008, 3'd0, 32'hF0, 3'd1, 32'h0F, 1'b1, 1'b0, 3'd0, 32'h0, 4'b0111};
        vt[9]  = '{16'h4340, 3'd0, 32'h2, 3'd1, 32'h3, 1'b0, 1'b1, 3'd0, 32'h0, 4'b0111};
        vt[10] = '{16'h4048, 3'd0, 32'hFF, 3'd1, 32'h0F, 1'b1, 1'b0, 3'd0, 32'hF0, 4'b0011};
        vt[11] = '{16'h4308, 3'd0, 32'h80000000, 3'd1, 32'h1, 1'b1, 1'b0, 3'd0, 32'h80000001, 4'b1011};
        vt[12] = '{16'h1A42, 3'd0, 32'h3, 3'd1, 32'h5, 1'b1, 1'b0, 3'd2, 32'hFFFFFFFE, 4'b1000};
        vt[13] = '{16'h4208, 3'd0, 32'h10, 3'd1, 32'h01, 1'b0, 1'b0, 3'd0, 32'h0, 4'b0100};
        vt[14] = '{16'h42C8, 3'd0, 32'hFFFFFFFF, 3'd1, 32'h1, 1'b0, 1'b0, 3'd0, 32'h0, 4'b0110};
        vt[15] = '{16'h4088, 3'd0, 32'h80000001, 3'd1, 32'h1, 1'b1, 1'b0, 3'd0, 32'h2, 4'b0010};
        vt[16] = '{16'h4108, 3'd0, 32'h80000000, 3'd1, 32'h4, 1'b1, 1'b0, 3'd0, 32'hF8000000, 4'b1000};
        vt[17] = '{16'h0000, 3'd0, 32'h0, 3'd1, 32'h0, 1'b0, 1'b1, 3'd0, 32'h0, 4'b1000};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst ready", {31'b0, instr_ready}, 32'd1);
        chk("rst apsr", {28'b0, apsr_nzcv}, 32'd0);
        chk("rst wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst wb_addr", {29'b0, wb_addr}, 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        chk("rst illegal", {31'b0, illegal}, 32'd0);
        chk("rst alu_a", alu_a, 32'd0);

        for (int i = 0; i < 18; i++) run(vt[i], i);

        // flush in EXEC drops the ADD; the retry is accepted in the very next cycle
        @(negedge clk);
        rf[0] = 32'h7FFFFFFF;
        rf[1] = 32'h1;
        instr = 16'h1842;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("fe ready_exec", {31'b0, instr_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("fe wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("fe illegal", {31'b0, illegal}, 32'd0);
        chk("fe apsr", {28'b0, apsr_nzcv}, 32'h8);
        chk("fe ready_idle", {31'b0, instr_ready}, 32'd1);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("fw wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("fw wb_data", wb_data, 32'h80000000);
        chk("fw apsr", {28'b0, apsr_nzcv}, 32'h9);
        @(negedge clk);
        flush = 1'b0;
        chk("fw ready", {31'b0, instr_ready}, 32'd1);

        // flush together with instr_valid in IDLE prevents acceptance
        instr_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("fi ready", {31'b0, instr_ready}, 32'd1);
        instr_valid = 1'b0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("fi wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("fi apsr", {28'b0, apsr_nzcv}, 32'h9);

        // reset during WB clears everything on the following edge
        rf[0] = 32'h3;
        rf[1] = 32'h5;
        instr = 16'h1A42;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rw wb_valid_pre", {31'b0, wb_valid}, 32'd1);
        chk("rw apsr_pre", {28'b0, apsr_nzcv}, 32'h8);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rw wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rw wb_addr", {29'b0, wb_addr}, 32'd0);
        chk("rw wb_data", wb_data, 32'd0);
        chk("rw apsr", {28'b0, apsr_nzcv}, 32'd0);
        chk("rw illegal", {31'b0, illegal}, 32'd0);
        chk("rw ready", {31'b0, instr_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
